// File: rtl/gb_joypad_p1.sv
// Game Boy P1/JOYP register at $FF00: select latch toward ICD2,
// nibble read-back with post-select settling, joypad irq and STOP wake.
module gb_joypad_p1 #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       sel,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic [1:0] joy_p54,
  input  logic [3:0] joy_din,
  output logic       irq,
  output logic       wake
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SETTLE_V = CW'(SETTLE);

  logic [1:0]    p54;
  logic [3:0]    nib;
  logic [CW-1:0] settle_cnt;
  logic          wr_hit;
  logic          p54_chg;

  assign wr_hit  = ce & sel & cpu_wr;
  assign p54_chg = cpu_di[5:4] != p54;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p54        <= 2'b11;
      nib        <= 4'hF;
      settle_cnt <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (ce) begin
        // Sampling decision uses the count as it stood before any write
        if (settle_cnt != '0) begin
          settle_cnt <= settle_cnt - CW'(1);
        end else begin
          nib <= joy_din;
          irq <= |(nib & ~joy_din);
        end
        if (wr_hit) begin
          p54 <= cpu_di[5:4];
          if (p54_chg) settle_cnt <= SETTLE_V;
        end
      end
    end
  end

  assign joy_p54 = p54;
  assign cpu_do  = sel ? {2'b11, p54, nib} : 8'hFF;
  assign wake    = ~&nib;

endmodule
